commit_store_buffer: RTL and testbench
======================================

Name: commit_store_buffer

Overview:
- Sits directly downstream of the retire stage's store port.
- Captures each retired store (retire_store_valid / retire_store_id), reads that store's address, data and byte mask from the store queue, and holds it in an in-order FIFO.
- Drains entries to data memory over a valid/ready handshake, then frees the store-queue entry.
- Retired stores are architectural: pipeline flush never discards buffer contents.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, store data width; mask width is DATA_WIDTH/8
- DEPTH, 8, buffer entries; power of two, at least 2
- SQ_ID_WIDTH, 4, store-queue index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- retire_store_valid  in  1  store retiring this cycle
- retire_store_id  in  SQ_ID_WIDTH  store-queue index of the retiring store
- sq_rd_id  out  SQ_ID_WIDTH  combinational store-queue read index; equals retire_store_id
- sq_rd_addr  in  ADDR_WIDTH  store address at sq_rd_id, same cycle
- sq_rd_data  in  DATA_WIDTH  store data at sq_rd_id
- sq_rd_mask  in  DATA_WIDTH/8  byte enables at sq_rd_id
- csb_full  out  1  count==DEPTH; retire must hold stores while high
- csb_empty  out  1  count==0
- csb_count  out  $clog2(DEPTH)+1  occupancy
- csb_overflow  out  1  sticky error flag
- mem_req_valid  out  1  head entry presented to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  head entry address
- mem_req_data  out  DATA_WIDTH  head entry data
- mem_req_mask  out  DATA_WIDTH/8  head entry byte mask
- sq_release_valid  out  1  one-cycle pulse: store-queue entry may be freed
- sq_release_id  out  SQ_ID_WIDTH  index being freed
- ld_addr  in  ADDR_WIDTH  load lookup address (CSB_LOAD_FWD_EN only)
- fwd_data  out  DATA_WIDTH  forwarded bytes (CSB_LOAD_FWD_EN only)
- fwd_mask  out  DATA_WIDTH/8  forwarded byte lanes (CSB_LOAD_FWD_EN only)

Behaviour:
- Reset (rst==0 at posedge): head, tail and count are zero; csb_overflow=0; sq_release_valid=0. mem_req_valid and csb_full read 0 and csb_empty reads 1 from the following cycle.
- Reset mid-drain drops the pending request and all entries; no release pulse is generated for them.
- Storage: circular array of {addr, data, mask, sq_id}. Head and tail pointers are log2(DEPTH) bits and wrap naturally. count is held in its own register, so full and empty are unambiguous.
- Enqueue when retire_store_valid && !csb_full. The entry is written at the tail from sq_rd_* and retire_store_id at the posedge; tail increments.
- retire_store_valid while csb_full: the store is dropped, csb_overflow is set (sticky until reset), and state is otherwise unchanged.
- mem_req_valid = !csb_empty. mem_req_addr, mem_req_data and mem_req_mask read directly from the head entry (storage registered, output mux combinational).
- Latency: a store enqueued at edge N into an empty buffer presents mem_req_valid in cycle N+1.
- Request fields are stable while mem_req_valid && !mem_req_ready, because the head moves only on handshake.
- Dequeue when mem_req_valid && mem_req_ready: head increments. At the next edge, sq_release_valid=1 and sq_release_id=the drained entry's sq_id; otherwise sq_release_valid=0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- csb_full is computed from the registered count, so no enqueue is accepted when count==DEPTH even if a dequeue occurs that cycle.
- Enqueue into an empty buffer with ready held high: one entry drains per cycle; throughput is one store per cycle.
- No flush input exists; contents survive any pipeline flush.

Optional Feature:
- CSB_LOAD_FWD_EN defined:
  - ld_addr is compared combinationally against every valid entry on word address (addr[ADDR_WIDTH-1:2]).
  - Per byte lane, data comes from the youngest matching entry whose mask bit is set.
  - fwd_mask is the OR of the matching masks; fwd_data is the merged bytes, with zero in uncovered lanes.
  - An entry being drained this cycle is still included.
- CSB_LOAD_FWD_EN undefined: ld_addr is ignored, fwd_data=0, fwd_mask=0, and no compare logic is built.

Test Plan:
- Reset, then one store (id=3, addr=0x100, data=0xDEADBEEF, mask=0xF) with ready=1: mem_req_valid in cycle 1 with the captured values; sq_release_valid=1, id=3 in cycle 2; csb_empty=1 afterwards.
- ready=0, enqueue 8 stores: csb_full=1 and count=8. A 9th store sets csb_overflow=1, count stays 8, and the head is still entry 0.
- Full buffer, ready=1 for 8 cycles while a new store retires in every cycle that csb_full==0: stores drain in enqueue order, tail wraps, and all release ids arrive in order.
- ready toggling 0/1 with the buffer non-empty: mem_req_addr/data/mask stay stable through every ready=0 cycle; no duplicate or skipped releases.
- rst driven low while 5 entries are pending and mem_req_valid=1: next cycle count=0, csb_empty=1, mem_req_valid=0, no release pulse.
- With CSB_LOAD_FWD_EN, entries (0x200, 0x11223344, 0xF) then (0x200, 0x0000AA00, 0x2) and ld_addr=0x200: fwd_mask=0xF, fwd_data=0x1122AA44. Without the macro, fwd_mask=0.

Source files
------------

// File: rtl/commit_store_buffer.sv
// In-order buffer of retired stores draining to data memory; frees store-queue entries on drain.
// Optional load forwarding from buffered stores is built when CSB_LOAD_FWD_EN is defined.
module commit_store_buffer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int SQ_ID_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      retire_store_valid,
    input  logic [SQ_ID_WIDTH-1:0]    retire_store_id,
    output logic [SQ_ID_WIDTH-1:0]    sq_rd_id,
    input  logic [ADDR_WIDTH-1:0]     sq_rd_addr,
    input  logic [DATA_WIDTH-1:0]     sq_rd_data,
    input  logic [DATA_WIDTH/8-1:0]   sq_rd_mask,
    output logic                      csb_full,
    output logic                      csb_empty,
    output logic [$clog2(DEPTH):0]    csb_count,
    output logic                      csb_overflow,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_data,
    output logic [DATA_WIDTH/8-1:0]   mem_req_mask,
    output logic                      sq_release_valid,
    output logic [SQ_ID_WIDTH-1:0]    sq_release_id,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [DATA_WIDTH/8-1:0]   fwd_mask
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [MASK_W-1:0]      mask_q [DEPTH];
    logic [SQ_ID_WIDTH-1:0] id_q   [DEPTH];

    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q;
    logic                   rel_valid_q;
    logic [SQ_ID_WIDTH-1:0] rel_id_q;

    logic enq, deq;

    // Full comes from the registered count, so a same-cycle drain never frees a slot for retire.
    assign csb_full      = (count_q == CNT_W'(DEPTH));
    assign csb_empty     = (count_q == '0);
    assign csb_count     = count_q;
    assign csb_overflow  = overflow_q;
    assign sq_rd_id      = retire_store_id;

    assign enq           = retire_store_valid && !csb_full;
    assign mem_req_valid = !csb_empty;
    assign deq           = mem_req_valid && mem_req_ready;

    assign mem_req_addr  = addr_q[head_q];
    assign mem_req_data  = data_q[head_q];
    assign mem_req_mask  = mask_q[head_q];

    assign sq_release_valid = rel_valid_q;
    assign sq_release_id    = rel_id_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) tail_d = tail_q + PTR_W'(1);
        if (deq) head_d = head_q + PTR_W'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_id_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            overflow_q  <= overflow_q | (retire_store_valid & csb_full);
            rel_valid_q <= deq;
            if (deq) rel_id_q <= id_q[head_q];
        end
    end

    // NOTE: the entry array is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sq_rd_addr;
            data_q[tail_q] <= sq_rd_data;
            mask_q[tail_q] <= sq_rd_mask;
            id_q[tail_q]   <= retire_store_id;
        end
    end

`ifdef CSB_LOAD_FWD_EN
    logic [PTR_W-1:0] fwd_idx;
    logic             unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (addr_q[fwd_idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (mask_q[fwd_idx][b]) begin
                        fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                        fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^ld_addr;
    assign fwd_data       = '0;
    assign fwd_mask       = '0;
`endif

endmodule

// File: tb/tb_commit_store_buffer.sv
// Scoreboard bench for commit_store_buffer: stimulus pushes expected drains, a monitor checks
// every memory handshake and the release pulse that must follow it one cycle later.
module tb_commit_store_buffer;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  id;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire_store_valid = 1'b0;
    logic [3:0]  retire_store_id = '0;
    logic [3:0]  sq_rd_id;
    logic [31:0] sq_rd_addr, sq_rd_data;
    logic [3:0]  sq_rd_mask;
    logic        csb_full, csb_empty, csb_overflow;
    logic [3:0]  csb_count;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        sq_release_valid;
    logic [3:0]  sq_release_id;
    logic [31:0] ld_addr = '0;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;

    // Behavioural store queue: combinational read at the DUT's requested index.
    logic [31:0] sq_addr_m [16];
    logic [31:0] sq_data_m [16];
    logic [3:0]  sq_mask_m [16];
    assign sq_rd_addr = sq_addr_m[sq_rd_id];
    assign sq_rd_data = sq_data_m[sq_rd_id];
    assign sq_rd_mask = sq_mask_m[sq_rd_id];

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic rel_pending = 1'b0;
    logic [3:0] rel_id_exp = '0;

    commit_store_buffer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(8), .SQ_ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .retire_store_valid(retire_store_valid), .retire_store_id(retire_store_id),
        .sq_rd_id(sq_rd_id), .sq_rd_addr(sq_rd_addr), .sq_rd_data(sq_rd_data),
        .sq_rd_mask(sq_rd_mask),
        .csb_full(csb_full), .csb_empty(csb_empty), .csb_count(csb_count),
        .csb_overflow(csb_overflow),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .sq_release_valid(sq_release_valid), .sq_release_id(sq_release_id),
        .ld_addr(ld_addr), .fwd_data(fwd_data), .fwd_mask(fwd_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input bit accept);
        sq_addr_m[id] = a;
        sq_data_m[id] = d;
        sq_mask_m[id] = m;
        retire_store_valid = 1'b1;
        retire_store_id = id;
        if (accept) exp_q.push_back('{a, d, m, id});
        step();
        retire_store_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        mem_req_ready = 1'b1;
        for (int k = 0; k < 40 && !csb_empty; k++) step();
        check(name, 64'(csb_empty), 64'(1));
    endtask

    // Monitor: compares every handshake against the scoreboard, then the release one cycle later.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (rel_pending || sq_release_valid) begin
                check("release_valid", 64'(sq_release_valid), 64'(rel_pending));
                if (rel_pending) check("release_id", 64'(sq_release_id), 64'(rel_id_exp));
            end
            rel_pending = 1'b0;
            if (rst && mem_req_valid && mem_req_ready) begin
                if (exp_q.size() == 0) begin
                    check("req_expected", 64'(exp_q.size()), 64'(1));
                end else begin
                    r = exp_q.pop_front();
                    check("req_addr", 64'(mem_req_addr), 64'(r.addr));
                    check("req_data", 64'(mem_req_data), 64'(r.data));
                    check("req_mask", 64'(mem_req_mask), 64'(r.mask));
                    rel_pending = 1'b1;
                    rel_id_exp  = r.id;
                end
            end
        end
    end

    initial begin
        logic [15:0] pat;
        logic [31:0] ha, hd;
        logic [3:0]  hm;
        logic        held;
        for (int i = 0; i < 16; i++) begin
            sq_addr_m[i] = '0;
            sq_data_m[i] = '0;
            sq_mask_m[i] = '0;
        end

        // Reset state
        repeat (3) step();
        check("rst_empty", 64'(csb_empty), 64'(1));
        check("rst_valid", 64'(mem_req_valid), 64'(0));
        check("rst_full", 64'(csb_full), 64'(0));
        check("rst_count", 64'(csb_count), 64'(0));
        check("rst_overflow", 64'(csb_overflow), 64'(0));
        check("rst_release", 64'(sq_release_valid), 64'(0));
        rst = 1'b1;
        step();

        // Single store, ready high: request next cycle, release the cycle after
        mem_req_ready = 1'b1;
        retire_store_id = 4'd3;
        #1;
        check("sq_rd_id", 64'(sq_rd_id), 64'(3));
        retire(4'd3, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1);
        check("single_valid", 64'(mem_req_valid), 64'(1));
        check("single_addr", 64'(mem_req_addr), 64'(32'h100));
        step();
        check("single_rel_valid", 64'(sq_release_valid), 64'(1));
        check("single_rel_id", 64'(sq_release_id), 64'(3));
        check("single_empty", 64'(csb_empty), 64'(1));

        // Fill with ready low, then overflow
        mem_req_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            retire(4'(i), 32'h1000 + 32'(i * 4), 32'h11111111 * 32'(i), 4'(i + 1), 1'b1);
        check("fill_full", 64'(csb_full), 64'(1));
        check("fill_count", 64'(csb_count), 64'(8));
        check("fill_no_ovf", 64'(csb_overflow), 64'(0));
        retire(4'd8, 32'h3000, 32'hBAD0BAD0, 4'hF, 1'b0);
        check("ovf_set", 64'(csb_overflow), 64'(1));
        check("ovf_count", 64'(csb_count), 64'(8));
        check("ovf_head", 64'(mem_req_addr), 64'(32'h1000));

        // Drain while refilling: first cycle full (no retire), then one retire per cycle
        mem_req_ready = 1'b1;
        step();
        for (int i = 0; i < 7; i++)
            retire(4'(9 + i), 32'h2000 + 32'(i * 4), 32'hA0000000 | 32'(i), 4'hF ^ 4'(i), 1'b1);
        check("refill_count", 64'(csb_count), 64'(7));
        check("refill_full", 64'(csb_full), 64'(0));
        check("ovf_sticky", 64'(csb_overflow), 64'(1));

        // Ready toggling: head fields must hold through every stalled cycle
        pat = 16'b1001_0110_0010_0100;
        for (int i = 0; i < 16; i++) begin
            mem_req_ready = pat[i];
            held = !pat[i] && mem_req_valid;
            ha = mem_req_addr;
            hd = mem_req_data;
            hm = mem_req_mask;
            step();
            if (held) begin
                check("stall_addr", 64'(mem_req_addr), 64'(ha));
                check("stall_data", 64'(mem_req_data), 64'(hd));
                check("stall_mask", 64'(mem_req_mask), 64'(hm));
            end
        end
        drain("toggle_drained");
        step();

        // Reset with 5 entries pending: everything dropped, no release
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            retire(4'(i), 32'h4000 + 32'(i * 4), 32'h55550000 | 32'(i), 4'hF, 1'b1);
        check("pend_count", 64'(csb_count), 64'(5));
        check("pend_valid", 64'(mem_req_valid), 64'(1));
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        check("mid_rst_count", 64'(csb_count), 64'(0));
        check("mid_rst_empty", 64'(csb_empty), 64'(1));
        check("mid_rst_valid", 64'(mem_req_valid), 64'(0));
        check("mid_rst_ovf", 64'(csb_overflow), 64'(0));
        check("mid_rst_release", 64'(sq_release_valid), 64'(0));
        mem_req_ready = 1'b1;
        repeat (3) step();
        check("post_rst_empty", 64'(csb_empty), 64'(1));

        // Load forwarding
        mem_req_ready = 1'b0;
        retire(4'd1, 32'h200, 32'h11223344, 4'hF, 1'b1);
        retire(4'd2, 32'h200, 32'h0000AA00, 4'h2, 1'b1);
        ld_addr = 32'h200;
        #1;
`ifdef CSB_LOAD_FWD_EN
        check("fwd_mask", 64'(fwd_mask), 64'(4'hF));
        check("fwd_data", 64'(fwd_data), 64'(32'h1122AA44));
        ld_addr = 32'h203;
        #1;
        check("fwd_same_word", 64'(fwd_data), 64'(32'h1122AA44));
        ld_addr = 32'h204;
        #1;
        check("fwd_miss_mask", 64'(fwd_mask), 64'(0));
        check("fwd_miss_data", 64'(fwd_data), 64'(0));
`else
        check("nofwd_mask", 64'(fwd_mask), 64'(0));
        check("nofwd_data", 64'(fwd_data), 64'(0));
`endif
        drain("fwd_drained");
        step();
        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
